// File: rtl/spgd_pkg.sv
// -----------------------------------------------------------------------------
// spgd_pkg
// Shared definitions for the SPGD perturbation/update stage:
//   - spgd_state_t : FSM state encoding used by spgd_update
//   - DEF_*        : default widths and mid-scale control value
//   - SUM_W        : width of every internal signed sum
//   - sat_ctrl     : clamp of a signed sum to [0, 2^width - 1]
// -----------------------------------------------------------------------------
package spgd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY_POS,
        MEAS_POS,
        APPLY_NEG,
        MEAS_NEG,
        UPDATE
    } spgd_state_t;

    localparam int DEF_CTRL_WIDTH   = 12;
    localparam int DEF_METRIC_WIDTH = 16;
    localparam int DEF_MID_SCALE    = 1 << (DEF_CTRL_WIDTH - 1);

    // Wide enough for CTRL_WIDTH + METRIC_WIDTH + 2 with generous headroom,
    // so u +/- DELTA and u +/- step can never wrap before clamping.
    localparam int SUM_W = 48;

    // Saturate a signed sum into the unsigned control range of 'width' bits.
    function automatic logic [SUM_W-1:0] sat_ctrl(input logic signed [SUM_W-1:0] v,
                                                  input int width);
        logic signed [SUM_W-1:0] maxv;
        maxv = {{(SUM_W-1){1'b0}}, 1'b1};
        maxv = (maxv << width) - {{(SUM_W-1){1'b0}}, 1'b1};
        if (v[SUM_W-1])
            sat_ctrl = '0;
        else if (v > maxv)
            sat_ctrl = maxv;
        else
            sat_ctrl = v;
    endfunction

endpackage

// File: rtl/spgd_channel.sv
// -----------------------------------------------------------------------------
// spgd_channel
// One actuator channel: holds the control value u, the latched random sign s,
// and the registered output word (u, u+s*DELTA or u-s*DELTA, all clamped).
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   rand_bit      : random sign bit, latched when load_pos is high (1 = +1)
//   load_pos      : enter the positive half (IDLE accepting enable)
//   load_neg      : enter the negative half (J+ accepted)
//   commit        : UPDATE cycle, apply u <- clamp(u + s*step)
//   step          : shared signed gradient step
//   ctrl          : registered channel output
// -----------------------------------------------------------------------------
module spgd_channel
    import spgd_pkg::*;
#(
    parameter int CTRL_WIDTH   = DEF_CTRL_WIDTH,
    parameter int METRIC_WIDTH = DEF_METRIC_WIDTH,
    parameter int DELTA        = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rand_bit,
    input  logic                           load_pos,
    input  logic                           load_neg,
    input  logic                           commit,
    input  logic signed [METRIC_WIDTH:0]   step,
    output logic        [CTRL_WIDTH-1:0]   ctrl
);

    localparam logic [CTRL_WIDTH-1:0] MID = {1'b1, {(CTRL_WIDTH-1){1'b0}}};

    logic [CTRL_WIDTH-1:0]   u;
    logic                    s;
    logic signed [SUM_W-1:0] u_ext, d_ext, st_ext;
    logic [SUM_W-1:0]        sat_up, sat_dn, sat_upd;
    logic                    unused_hi;

    // Both perturbed candidates and the updated value are formed every cycle
    // in wide signed arithmetic and clamped before use.
    always_comb begin
        u_ext   = {{(SUM_W-CTRL_WIDTH){1'b0}}, u};
        d_ext   = SUM_W'(DELTA);
        st_ext  = {{(SUM_W-METRIC_WIDTH-1){step[METRIC_WIDTH]}}, step};
        sat_up  = sat_ctrl(u_ext + d_ext, CTRL_WIDTH);
        sat_dn  = sat_ctrl(u_ext - d_ext, CTRL_WIDTH);
        sat_upd = sat_ctrl(s ? (u_ext + st_ext) : (u_ext - st_ext), CTRL_WIDTH);
    end

    assign unused_hi = ^{sat_up[SUM_W-1:CTRL_WIDTH], sat_dn[SUM_W-1:CTRL_WIDTH],
                         sat_upd[SUM_W-1:CTRL_WIDTH]};

    // The incoming random bit is used directly on load_pos so the perturbed
    // value is visible in the very first APPLY_POS cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            u    <= MID;
            s    <= 1'b0;
            ctrl <= MID;
        end else if (load_pos) begin
            s    <= rand_bit;
            ctrl <= rand_bit ? sat_up[CTRL_WIDTH-1:0] : sat_dn[CTRL_WIDTH-1:0];
        end else if (load_neg) begin
            ctrl <= s ? sat_dn[CTRL_WIDTH-1:0] : sat_up[CTRL_WIDTH-1:0];
        end else if (commit) begin
            u    <= sat_upd[CTRL_WIDTH-1:0];
            ctrl <= sat_upd[CTRL_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/spgd_update.sv
// -----------------------------------------------------------------------------
// spgd_update
// Two-sided SPGD perturbation and update stage. Each iteration latches one
// random sign per channel, applies u+s*DELTA then u-s*DELTA, requests a metric
// sample after each settle period, then updates u by s*((J+ - J-) >>> GAIN_SHIFT).
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   random        : one sign bit per channel (1 = +1, 0 = -1)
//   enable        : start/continue iterating (sampled only in IDLE)
//   metric        : unsigned cost metric, higher is better
//   metric_valid  : metric valid this cycle
//   meas_req      : high while waiting for a metric sample
//   ctrl_out      : channel i at [i*CTRL_WIDTH +: CTRL_WIDTH], registered
//   iter_count    : (SPGD_ITER_CNT_EN only) 16-bit wrapping count of updates
//   iter_done     : one-cycle pulse when an update is committed
// Optional feature macro: SPGD_ITER_CNT_EN
// -----------------------------------------------------------------------------
module spgd_update
    import spgd_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int CTRL_WIDTH    = DEF_CTRL_WIDTH,
    parameter int METRIC_WIDTH  = DEF_METRIC_WIDTH,
    parameter int DELTA         = 8,
    parameter int GAIN_SHIFT    = 6,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            random,
    input  logic                           enable,
    input  logic [METRIC_WIDTH-1:0]        metric,
    input  logic                           metric_valid,
    output logic                           meas_req,
    output logic [CHANNELS*CTRL_WIDTH-1:0] ctrl_out,
`ifdef SPGD_ITER_CNT_EN
    output logic [15:0]                    iter_count,
`endif
    output logic                           iter_done
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    spgd_state_t               state;
    logic [CNT_W-1:0]          settle_cnt;
    logic [METRIC_WIDTH-1:0]   j_pos, j_neg;
    logic signed [METRIC_WIDTH:0] dj, step;
    logic                      load_pos, load_neg, commit;

    // Channel strobes are decoded from the current state so the channels load
    // on the same edge that the FSM changes phase.
    assign load_pos = (state == IDLE)     && enable;
    assign load_neg = (state == MEAS_POS) && metric_valid;
    assign commit   = (state == UPDATE);

    // Zero-extend both metrics by one bit so the difference is a correct
    // signed value; >>> then floors toward minus infinity.
    assign dj   = $signed({1'b0, j_pos}) - $signed({1'b0, j_neg});
    assign step = dj >>> GAIN_SHIFT;

    // Main FSM: settle counting, metric capture, registered meas_req/iter_done.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            j_pos      <= '0;
            j_neg      <= '0;
            meas_req   <= 1'b0;
            iter_done  <= 1'b0;
`ifdef SPGD_ITER_CNT_EN
            iter_count <= '0;
`endif
        end else begin
            iter_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        settle_cnt <= '0;
                        state      <= APPLY_POS;
                    end
                end
                APPLY_POS: begin
                    if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        meas_req <= 1'b1;
                        state    <= MEAS_POS;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                MEAS_POS: begin
                    if (metric_valid) begin
                        j_pos      <= metric;
                        meas_req   <= 1'b0;
                        settle_cnt <= '0;
                        state      <= APPLY_NEG;
                    end
                end
                APPLY_NEG: begin
                    if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        meas_req <= 1'b1;
                        state    <= MEAS_NEG;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                MEAS_NEG: begin
                    if (metric_valid) begin
                        j_neg     <= metric;
                        meas_req  <= 1'b0;
                        iter_done <= 1'b1;
                        state     <= UPDATE;
                    end
                end
                UPDATE: begin
`ifdef SPGD_ITER_CNT_EN
                    iter_count <= iter_count + 16'd1;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        spgd_channel #(
            .CTRL_WIDTH  (CTRL_WIDTH),
            .METRIC_WIDTH(METRIC_WIDTH),
            .DELTA       (DELTA)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .rand_bit(random[i]),
            .load_pos(load_pos),
            .load_neg(load_neg),
            .commit  (commit),
            .step    (step),
            .ctrl    (ctrl_out[i*CTRL_WIDTH +: CTRL_WIDTH])
        );
    end

endmodule

// File: tb/tb_spgd_update.sv
// -----------------------------------------------------------------------------
// tb_spgd_update
// Table-driven bench for spgd_update with SETTLE_CYCLES = 4, plus hand-written
// sequences for reset, mid-operation reset and enable drop.
// -----------------------------------------------------------------------------
module tb_spgd_update;

    localparam int S = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  random;
    logic        enable;
    logic [15:0] metric;
    logic        metric_valid;
    logic        meas_req;
    logic [47:0] ctrl_out;
    logic        iter_done;
`ifdef SPGD_ITER_CNT_EN
    logic [15:0] iter_count;
`endif

    spgd_update #(
        .CHANNELS     (4),
        .CTRL_WIDTH   (12),
        .METRIC_WIDTH (16),
        .DELTA        (8),
        .GAIN_SHIFT   (6),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .random      (random),
        .enable      (enable),
        .metric      (metric),
        .metric_valid(metric_valid),
        .meas_req    (meas_req),
        .ctrl_out    (ctrl_out),
`ifdef SPGD_ITER_CNT_EN
        .iter_count  (iter_count),
`endif
        .iter_done   (iter_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_first;
        logic        noisy;
        logic [3:0]  rnd;
        logic [15:0] jp;
        logic [15:0] jn;
        logic [47:0] pos;
        logic [47:0] neg;
        logic [47:0] u;
    } vec_t;

    vec_t vecs [9];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic logic [47:0] pk(input int c3, input int c2, input int c1, input int c0);
        return {c3[11:0], c2[11:0], c1[11:0], c0[11:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst          = 1'b0;
        enable       = 1'b0;
        metric_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One full iteration driven from IDLE, checking every phase boundary.
    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        if (v.rst_first) doReset();
        random       = v.rnd;
        enable       = 1'b1;
        metric       = 16'hBEEF;
        metric_valid = v.noisy;
        @(negedge clk);
        enable = 1'b0;
        checkOutput({tag, ".pos"}, ctrl_out, v.pos);
        checkOutput({tag, ".req_lo1"}, meas_req, 1'b0);
        repeat (S-1) @(negedge clk);
        checkOutput({tag, ".req_early1"}, meas_req, 1'b0);
        @(negedge clk);
        checkOutput({tag, ".req_hi1"}, meas_req, 1'b1);
        checkOutput({tag, ".pos_hold"}, ctrl_out, v.pos);
        metric       = v.jp;
        metric_valid = 1'b1;
        @(negedge clk);
        checkOutput({tag, ".neg"}, ctrl_out, v.neg);
        checkOutput({tag, ".req_lo2"}, meas_req, 1'b0);
        metric       = 16'hBEEF;
        metric_valid = v.noisy;
        repeat (S-1) @(negedge clk);
        checkOutput({tag, ".req_early2"}, meas_req, 1'b0);
        @(negedge clk);
        checkOutput({tag, ".req_hi2"}, meas_req, 1'b1);
        metric       = v.jn;
        metric_valid = 1'b1;
        @(negedge clk);
        checkOutput({tag, ".done_hi"}, iter_done, 1'b1);
        checkOutput({tag, ".neg_hold"}, ctrl_out, v.neg);
        metric       = 16'hBEEF;
        metric_valid = v.noisy;
        @(negedge clk);
        checkOutput({tag, ".done_lo"}, iter_done, 1'b0);
        checkOutput({tag, ".u"}, ctrl_out, v.u);
        checkOutput({tag, ".req_idle"}, meas_req, 1'b0);
        metric_valid = 1'b0;
    endtask

    initial begin
        int pulses;
        int reqs;

        vecs[0] = '{1'b1, 1'b0, 4'b0101, 16'd1000, 16'd360,
                    pk(2040, 2056, 2040, 2056), pk(2056, 2040, 2056, 2040), pk(2038, 2058, 2038, 2058)};
        vecs[1] = '{1'b1, 1'b1, 4'b0001, 16'd100, 16'd200,
                    pk(2040, 2040, 2040, 2056), pk(2056, 2056, 2056, 2040), pk(2050, 2050, 2050, 2046)};
        vecs[2] = '{1'b1, 1'b0, 4'b1111, 16'd65535, 16'd0,
                    pk(2056, 2056, 2056, 2056), pk(2040, 2040, 2040, 2040), pk(3071, 3071, 3071, 3071)};
        vecs[3] = '{1'b0, 1'b1, 4'b1111, 16'd65535, 16'd0,
                    pk(3079, 3079, 3079, 3079), pk(3063, 3063, 3063, 3063), pk(4094, 4094, 4094, 4094)};
        vecs[4] = '{1'b0, 1'b0, 4'b1111, 16'd65535, 16'd0,
                    pk(4095, 4095, 4095, 4095), pk(4086, 4086, 4086, 4086), pk(4095, 4095, 4095, 4095)};
        vecs[5] = '{1'b0, 1'b0, 4'b1111, 16'd65535, 16'd0,
                    pk(4095, 4095, 4095, 4095), pk(4087, 4087, 4087, 4087), pk(4095, 4095, 4095, 4095)};
        vecs[6] = '{1'b0, 1'b0, 4'b0000, 16'd0, 16'd64,
                    pk(4087, 4087, 4087, 4087), pk(4095, 4095, 4095, 4095), pk(4095, 4095, 4095, 4095)};
        vecs[7] = '{1'b0, 1'b1, 4'b0000, 16'd6400, 16'd0,
                    pk(4087, 4087, 4087, 4087), pk(4095, 4095, 4095, 4095), pk(3995, 3995, 3995, 3995)};
        vecs[8] = '{1'b1, 1'b0, 4'b0001, 16'd5, 16'd6,
                    pk(2040, 2040, 2040, 2056), pk(2056, 2056, 2056, 2040), pk(2049, 2049, 2049, 2047)};

        rst          = 1'b0;
        random       = 4'b0000;
        enable       = 1'b0;
        metric       = 16'd0;
        metric_valid = 1'b0;

        // Reset state and idling with enable low
        @(negedge clk);
        checkOutput("rst.ctrl", ctrl_out, pk(2048, 2048, 2048, 2048));
        checkOutput("rst.req", meas_req, 1'b0);
        checkOutput("rst.done", iter_done, 1'b0);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("idle.ctrl", ctrl_out, pk(2048, 2048, 2048, 2048));
        checkOutput("idle.req", meas_req, 1'b0);
        checkOutput("idle.done", iter_done, 1'b0);

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

        // Reset while waiting in MEAS_NEG
        doReset();
        random = 4'b1010;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (S) @(negedge clk);
        metric       = 16'd500;
        metric_valid = 1'b1;
        @(negedge clk);
        metric_valid = 1'b0;
        repeat (S) @(negedge clk);
        checkOutput("midrst.in_meas", meas_req, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst.ctrl", ctrl_out, pk(2048, 2048, 2048, 2048));
        checkOutput("midrst.req", meas_req, 1'b0);
        checkOutput("midrst.done", iter_done, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst.done2", iter_done, 1'b0);
        checkOutput("midrst.ctrl2", ctrl_out, pk(2048, 2048, 2048, 2048));

        // Enable dropped during APPLY_NEG: iteration completes, then stays idle
        doReset();
        random = 4'b0101;
        enable = 1'b1;
        @(negedge clk);
        repeat (S) @(negedge clk);
        metric       = 16'd1000;
        metric_valid = 1'b1;
        @(negedge clk);
        enable       = 1'b0;
        metric_valid = 1'b0;
        repeat (S) @(negedge clk);
        metric       = 16'd360;
        metric_valid = 1'b1;
        @(negedge clk);
        metric_valid = 1'b0;
        checkOutput("drop.done_hi", iter_done, 1'b1);
        pulses = 0;
        reqs   = 0;
        for (int k = 0; k < 2*S + 6; k++) begin
            @(negedge clk);
            if (iter_done) pulses++;
            if (meas_req) reqs++;
        end
        checkOutput("drop.extra_done", pulses, 0);
        checkOutput("drop.extra_req", reqs, 0);
        checkOutput("drop.u", ctrl_out, pk(2038, 2058, 2038, 2058));
`ifdef SPGD_ITER_CNT_EN
        checkOutput("drop.iter_count", iter_count, 16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spgd_update.md
# spgd_update

Two-sided SPGD perturbation and update stage, directly downstream of the pseudo-random bit generator. Each iteration latches one random sign per actuator channel and applies `u + s·DELTA`, then `u − s·DELTA`. It requests one metric sample per half, then updates the control vector by `s·((J+ − J−) >>> GAIN_SHIFT)` with saturation. `ctrl_out` drives the actuator DAC interface.

## Interface
- `CHANNELS`, 4: number of actuator channels; also the number of random bits consumed.
- `CTRL_WIDTH`, 12: unsigned control word width per channel.
- `METRIC_WIDTH`, 16: unsigned metric width.
- `DELTA`, 8: perturbation amplitude in control LSBs.
- `GAIN_SHIFT`, 6: right-shift applied to the metric difference (gain = 2^−GAIN_SHIFT).
- `SETTLE_CYCLES`, 64: cycles held in each perturbed state before a metric request; must be ≥1.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-low reset (0 = reset).
- `random` in CHANNELS: random bits from the generator. Bit i = 1 means s_i = +1; bit i = 0 means s_i = −1.
- `enable` in 1: start or continue iterating.
- `metric` in METRIC_WIDTH: measured cost metric, unsigned, higher is better.
- `metric_valid` in 1: `metric` is valid this cycle.
- `meas_req` out 1: high while waiting for a metric sample.
- `ctrl_out` out CHANNELS·CTRL_WIDTH: channel i is at bits `[i·CTRL_WIDTH +: CTRL_WIDTH]`; registered output.
- `iter_done` out 1: one-cycle pulse when an update is committed.

## Operation
- FSM states: IDLE, APPLY_POS, MEAS_POS, APPLY_NEG, MEAS_NEG, UPDATE.
- IDLE:
  - `ctrl_out` = u.
  - If `enable` = 1: latch `random` into sign register s, go to APPLY_POS.
- APPLY_POS:
  - `ctrl_out` = clamp(u + s·DELTA).
  - Hold for SETTLE_CYCLES cycles, then go to MEAS_POS.
- MEAS_POS:
  - `ctrl_out` holds its APPLY_POS value; `meas_req` = 1.
  - On `metric_valid`: capture J+, go to APPLY_NEG.
- APPLY_NEG / MEAS_NEG: same as the positive half using clamp(u − s·DELTA); captures J−.
- UPDATE (one cycle):
  - dJ = J+ − J−, signed METRIC_WIDTH+1 bits.
  - step = dJ >>> GAIN_SHIFT (arithmetic shift, floors toward −∞).
  - u_i ← clamp(u_i + s_i·step).
  - Pulse `iter_done`, go to IDLE.
- clamp: saturates to [0, 2^CTRL_WIDTH − 1]. Internal sums are at least CTRL_WIDTH+METRIC_WIDTH+2 bits wide, so no wrap-around is possible.
- `enable` is sampled only in IDLE. Deasserting it mid-iteration completes the current iteration.
- `metric_valid` outside the MEAS states is ignored. It is accepted in the first cycle of a MEAS state.
- Reset mid-operation:
  - State → IDLE.
  - u_i → 2^(CTRL_WIDTH−1).
  - J± → 0; no `iter_done`.

## Timing
- Reset values:
  - `ctrl_out` = 2^(CTRL_WIDTH−1) on every channel (2048 for 12 bits).
  - `meas_req` = 0, `iter_done` = 0.
- `ctrl_out` shows the perturbed value in the first cycle of APPLY_POS, i.e. one cycle after IDLE sees `enable`.
- `meas_req` rises exactly SETTLE_CYCLES cycles after the perturbed value appears.
- `meas_req` falls in the cycle after `metric_valid` is accepted.
- The updated u appears on `ctrl_out` in the cycle after UPDATE (IDLE), coincident with `iter_done` falling.
- Minimum iteration with `metric_valid` held high: 2·SETTLE_CYCLES + 4 cycles, IDLE to IDLE.

## Configuration
- `SPGD_ITER_CNT_EN` defined:
  - Adds output `iter_count` (16 bits, reset 0), incremented on each `iter_done` and wrapping at 65535→0.
- `SPGD_ITER_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `spgd_pkg` holds:
  - The FSM state enum.
  - A `sat_ctrl` clamp function.
  - A default-constants set (mid-scale value, internal sum width).
- Sub-module `spgd_channel` is generated CHANNELS times. Each instance:
  - Holds u_i.
  - Forms the ±DELTA perturbed output.
  - Applies the saturating update from the shared `step`, s_i and the FSM phase.
- The top level owns the FSM, settle counter, J± capture and dJ/step computation.

## Test plan
All cases use CHANNELS=4, CTRL_WIDTH=12, DELTA=8, GAIN_SHIFT=6, SETTLE_CYCLES=4.
- **Reset:** `rst`=0 for 1 cycle → all channels 2048, `meas_req`=0, `iter_done`=0; stays idle with `enable`=0.
- **Basic iteration:** `random`=4'b0101, J+=1000, J−=360.
  - APPLY_POS `ctrl_out` = {2040, 2056, 2040, 2056} (ch3..ch0).
  - APPLY_NEG = {2056, 2040, 2056, 2040}.
  - Final u = {2038, 2058, 2038, 2058}.
  - `iter_done` pulses once.
- **Negative difference:** `random`=4'b0001, J+=100, J−=200 → step = −2; ch0 = 2046, ch1..3 = 2050.
- **Saturation:** `random`=4'b1111, J+=65535, J−=0 on every iteration.
  - Step = 1023; u goes 2048 → 3071 → 4094 → 4095 → 4095.
  - Perturbed output stays clamped at 4095, never wraps.
- **Reset mid-operation:** `rst`=0 while in MEAS_NEG → next cycle `ctrl_out`=2048 on all channels, `meas_req`=0, no `iter_done`.
- **Enable drop:** `enable` deasserted during APPLY_NEG → iteration completes, `iter_done` pulses once, block remains in IDLE with no further `meas_req`.
